// File: rtl/pipeline_redirect_controller_if.sv
// Execute/CSR/fetch bundle for the pipeline redirect controller.
// RAFI_REDIRECT_STATS_EN adds the event statistics counters to the bundle.
// master: execute stage / CSR unit side that drives the inputs.
// slave: the controller itself.
interface pipeline_redirect_controller_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CAUSE_WIDTH = 5
);
  logic                   exValid;
  logic [ADDR_WIDTH-1:0]  exPc;
  logic                   exBranchTaken;
  logic [ADDR_WIDTH-1:0]  exBranchTarget;
  logic                   exTrapValid;
  logic [CAUSE_WIDTH-1:0] exTrapCause;
  logic [ADDR_WIDTH-1:0]  exTrapValue;
  logic                   exTrapReturn;
  logic                   memStall;
  logic [ADDR_WIDTH-1:0]  csrTrapVector;
  logic [ADDR_WIDTH-1:0]  csrEpc;

  logic                   csrTrapWe;
  logic [ADDR_WIDTH-1:0]  csrTrapEpc;
  logic [CAUSE_WIDTH-1:0] csrTrapCause;
  logic [ADDR_WIDTH-1:0]  csrTrapTval;
  logic                   csrTrapReturnWe;
  logic                   flush;
  logic                   redirectValid;
  logic [ADDR_WIDTH-1:0]  redirectPc;
  logic                   busy;

`ifdef RAFI_REDIRECT_STATS_EN
  logic [31:0]            statBranchRedirects;
  logic [31:0]            statTraps;
  logic [31:0]            statTrapReturns;

  modport master (
    output exValid, exPc, exBranchTaken, exBranchTarget, exTrapValid,
           exTrapCause, exTrapValue, exTrapReturn, memStall,
           csrTrapVector, csrEpc,
    input  csrTrapWe, csrTrapEpc, csrTrapCause, csrTrapTval, csrTrapReturnWe,
           flush, redirectValid, redirectPc, busy,
           statBranchRedirects, statTraps, statTrapReturns
  );

  modport slave (
    input  exValid, exPc, exBranchTaken, exBranchTarget, exTrapValid,
           exTrapCause, exTrapValue, exTrapReturn, memStall,
           csrTrapVector, csrEpc,
    output csrTrapWe, csrTrapEpc, csrTrapCause, csrTrapTval, csrTrapReturnWe,
           flush, redirectValid, redirectPc, busy,
           statBranchRedirects, statTraps, statTrapReturns
  );
`else
  modport master (
    output exValid, exPc, exBranchTaken, exBranchTarget, exTrapValid,
           exTrapCause, exTrapValue, exTrapReturn, memStall,
           csrTrapVector, csrEpc,
    input  csrTrapWe, csrTrapEpc, csrTrapCause, csrTrapTval, csrTrapReturnWe,
           flush, redirectValid, redirectPc, busy
  );

  modport slave (
    input  exValid, exPc, exBranchTaken, exBranchTarget, exTrapValid,
           exTrapCause, exTrapValue, exTrapReturn, memStall,
           csrTrapVector, csrEpc,
    output csrTrapWe, csrTrapEpc, csrTrapCause, csrTrapTval, csrTrapReturnWe,
           flush, redirectValid, redirectPc, busy
  );
`endif
endinterface

// File: rtl/pipeline_redirect_controller.sv
// Pipeline redirect controller: owns the squash-and-restart decision for
// branches, traps and xRET leaving the execute stage.
// Optional build macro RAFI_REDIRECT_STATS_EN adds per-event counters.
//
// state         | meaning
// IDLE          | waiting for an unstalled execute-stage event
// REDIRECT      | branch / xRET restart cycle (flush + redirect)
// TRAP_WRITE    | commit epc/cause/tval to the CSR unit, flush
// TRAP_REDIRECT | restart fetch at the CSR trap vector, flush
// DRAIN         | hold flush for FLUSH_CYCLES more cycles
module pipeline_redirect_controller #(
  parameter int ADDR_WIDTH   = 32,
  parameter int CAUSE_WIDTH  = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_redirect_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    REDIRECT      = 3'd1,
    TRAP_WRITE    = 3'd2,
    TRAP_REDIRECT = 3'd3,
    DRAIN         = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  target_q, target_d;
  logic                   is_ret_q, is_ret_d;
  logic [ADDR_WIDTH-1:0]  epc_q, epc_d;
  logic [CAUSE_WIDTH-1:0] cause_q, cause_d;
  logic [ADDR_WIDTH-1:0]  tval_q, tval_d;
  logic                   accept;

`ifdef RAFI_REDIRECT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_trap_q, stat_trap_d;
  logic [31:0] stat_ret_q, stat_ret_d;
`endif

  // Next-state and latch logic; ex* inputs only matter while IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    is_ret_d = is_ret_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    accept   = (state_q == IDLE) && bus.exValid && !bus.memStall;
`ifdef RAFI_REDIRECT_STATS_EN
    stat_br_d   = stat_br_q;
    stat_trap_d = stat_trap_q;
    stat_ret_d  = stat_ret_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.exTrapValid) begin
            epc_d   = bus.exPc;
            cause_d = bus.exTrapCause;
            tval_d  = bus.exTrapValue;
            state_d = TRAP_WRITE;
`ifdef RAFI_REDIRECT_STATS_EN
            stat_trap_d = stat_trap_q + 32'd1;
`endif
          end else if (bus.exTrapReturn) begin
            // epc is captured now; the CSR unit may change it afterwards.
            target_d = bus.csrEpc;
            is_ret_d = 1'b1;
            state_d  = REDIRECT;
`ifdef RAFI_REDIRECT_STATS_EN
            stat_ret_d = stat_ret_q + 32'd1;
`endif
          end else if (bus.exBranchTaken) begin
            target_d = bus.exBranchTarget;
            is_ret_d = 1'b0;
            state_d  = REDIRECT;
`ifdef RAFI_REDIRECT_STATS_EN
            stat_br_d = stat_br_q + 32'd1;
`endif
          end
        end
      end
      REDIRECT:      state_d = IDLE;
      TRAP_WRITE:    state_d = TRAP_REDIRECT;
      TRAP_REDIRECT: begin
        cnt_d   = 4'(FLUSH_CYCLES);
        state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a bad count can never wedge the FSM.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      is_ret_q <= 1'b0;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
`ifdef RAFI_REDIRECT_STATS_EN
      stat_br_q   <= '0;
      stat_trap_q <= '0;
      stat_ret_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      is_ret_q <= is_ret_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
`ifdef RAFI_REDIRECT_STATS_EN
      stat_br_q   <= stat_br_d;
      stat_trap_q <= stat_trap_d;
      stat_ret_q  <= stat_ret_d;
`endif
    end
  end

  // Output decode from registered state; payloads are zero when not strobed.
  // The trap vector is passed straight through because the CSR unit only
  // presents it in the cycle after the trap write.
  always_comb begin
    bus.flush           = (state_q != IDLE);
    bus.busy            = (state_q != IDLE);
    bus.redirectValid   = 1'b0;
    bus.redirectPc      = '0;
    bus.csrTrapWe       = 1'b0;
    bus.csrTrapEpc      = '0;
    bus.csrTrapCause    = '0;
    bus.csrTrapTval     = '0;
    bus.csrTrapReturnWe = 1'b0;
    case (state_q)
      REDIRECT: begin
        bus.redirectValid   = 1'b1;
        bus.redirectPc      = target_q;
        bus.csrTrapReturnWe = is_ret_q;
      end
      TRAP_WRITE: begin
        bus.csrTrapWe    = 1'b1;
        bus.csrTrapEpc   = epc_q;
        bus.csrTrapCause = cause_q;
        bus.csrTrapTval  = tval_q;
      end
      TRAP_REDIRECT: begin
        bus.redirectValid = 1'b1;
        bus.redirectPc    = bus.csrTrapVector;
      end
      default: ;
    endcase
  end

`ifdef RAFI_REDIRECT_STATS_EN
  assign bus.statBranchRedirects = stat_br_q;
  assign bus.statTraps           = stat_trap_q;
  assign bus.statTrapReturns     = stat_ret_q;
`endif

endmodule
